main_memory: RTL and testbench

Dual-port main memory model with fixed access latency, sitting directly downstream of the instruction and data caches. It serves line-wide fill (read) and evict (write) requests from both caches over their req/ack handshakes. A single storage array is shared between the two ports, with one access in flight at a time. Arbitration is round-robin between ports, and within a port a pending write is always served before its read.

---
 rtl/main_memory.sv | 146 ++++++++++++++
 tb/tb_main_memory.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/main_memory.sv
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef REG_SIZE
`define REG_SIZE 32
`endif

// Two-port line store shared by the I$ and D$; one access in flight, round-robin between ports, write before read within a port.
// Latency: request sampled in IDLE -> ack LATENCY cycles later; consecutive acks at least LATENCY+2 apart.
// Backpressure: req is held until its ack; a losing or queued request simply waits in IDLE arbitration.
module main_memory #(
    parameter int    WIDTH     = `WIDTH,
    parameter int    LINES     = 4096,
    parameter int    LATENCY   = 10,
    parameter string INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem0_write_req,
    input  logic [`REG_SIZE-1:0] mem0_write_addr,
    input  logic [WIDTH-1:0]     mem0_write_data,
    output logic                 mem0_write_ack,
    input  logic                 mem0_read_req,
    input  logic [`REG_SIZE-1:0] mem0_read_addr,
    output logic [WIDTH-1:0]     mem0_read_data,
    output logic                 mem0_read_ack,
    input  logic                 mem1_write_req,
    input  logic [`REG_SIZE-1:0] mem1_write_addr,
    input  logic [WIDTH-1:0]     mem1_write_data,
    output logic                 mem1_write_ack,
    input  logic                 mem1_read_req,
    input  logic [`REG_SIZE-1:0] mem1_read_addr,
    output logic [WIDTH-1:0]     mem1_read_data,
    output logic                 mem1_read_ack
);
    localparam int         WB       = $clog2(WIDTH / 8);
    localparam int         IW       = $clog2(LINES);
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] { IDLE = 2'd0, BUSY = 2'd1, ACK = 2'd2 } state_t;

    typedef struct packed {
        logic             port;
        logic             wr;
        logic [IW-1:0]    idx;
        logic [WIDTH-1:0] dat;
    } req_t;

    logic [WIDTH-1:0] mem [LINES];
    state_t           state, state_nxt;
    req_t             cur, sel;
    logic [7:0]       cnt;
    logic             last_grant;
    logic             pend0, pend1, grant, done;
    logic             w0_ack_nxt, r0_ack_nxt, w1_ack_nxt, r1_ack_nxt;
    logic             unused_addr_bits;

    // Offset and wrap-around address bits carry no information for the array.
    assign unused_addr_bits = ^{mem0_write_addr, mem0_read_addr, mem1_write_addr, mem1_read_addr};

    // Power-up contents; the array has no reset so its contents survive reset.
    initial begin
        for (int i = 0; i < LINES; i++) mem[i] = '0;
    end

    always_comb begin
        sel   = '0;
        pend0 = mem0_write_req | mem0_read_req;
        pend1 = mem1_write_req | mem1_read_req;
        grant = (pend0 & pend1) ? ~last_grant : pend1;
        sel.port = grant;
        sel.wr   = grant ? mem1_write_req : mem0_write_req;
        sel.dat  = grant ? mem1_write_data : mem0_write_data;
        case ({grant, sel.wr})
            2'b00:   sel.idx = mem0_read_addr[WB+IW-1:WB];
            2'b01:   sel.idx = mem0_write_addr[WB+IW-1:WB];
            2'b10:   sel.idx = mem1_read_addr[WB+IW-1:WB];
            default: sel.idx = mem1_write_addr[WB+IW-1:WB];
        endcase
    end

    assign done = (state == BUSY) && (cnt == 8'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pend0 | pend1) state_nxt = BUSY;
            BUSY:    if (cnt == 8'd0) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ack values for the next cycle; they are flopped so outputs never see inputs combinationally.
    always_comb begin
        w0_ack_nxt = done & ~cur.port &  cur.wr;
        r0_ack_nxt = done & ~cur.port & ~cur.wr;
        w1_ack_nxt = done &  cur.port &  cur.wr;
        r1_ack_nxt = done &  cur.port & ~cur.wr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            last_grant     <= 1'b1;
            cur            <= '0;
            mem0_write_ack <= 1'b0;
            mem0_read_ack  <= 1'b0;
            mem1_write_ack <= 1'b0;
            mem1_read_ack  <= 1'b0;
            mem0_read_data <= '0;
            mem1_read_data <= '0;
        end else begin
            state          <= state_nxt;
            mem0_write_ack <= w0_ack_nxt;
            mem0_read_ack  <= r0_ack_nxt;
            mem1_write_ack <= w1_ack_nxt;
            mem1_read_ack  <= r1_ack_nxt;
            case (state)
                IDLE: begin
                    if (pend0 | pend1) begin
                        cur <= sel;
                        cnt <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else if (!cur.wr) begin
                        if (cur.port) mem1_read_data <= mem[cur.idx];
                        else          mem0_read_data <= mem[cur.idx];
                    end
                end
                ACK:     last_grant <= cur.port;
                default: ;
            endcase
        end
    end

    // Reset forces IDLE asynchronously, so an interrupted write never reaches the array.
    always_ff @(posedge clk) begin
        if (done && cur.wr) mem[cur.idx] <= cur.dat;
    end

endmodule

// File: tb/tb_main_memory.sv
`ifndef REG_SIZE
`define REG_SIZE 32
`endif

// Bench for main_memory: timeline reference model checked every cycle, directed scenarios with literal expectations, random two-port traffic.
module tb_main_memory;
    localparam int W      = 32;
    localparam int LINES  = 16;
    localparam int LAT    = 10;
    localparam int BYTES  = W / 8;
    localparam int AW     = `REG_SIZE;
    localparam int BUDGET = 100;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    w_req = '0;
    logic [1:0]    r_req = '0;
    logic [AW-1:0] w_addr [2] = '{default: '0};
    logic [AW-1:0] r_addr [2] = '{default: '0};
    logic [W-1:0]  w_dat  [2] = '{default: '0};
    logic          w_ack0, w_ack1, r_ack0, r_ack1;
    logic [W-1:0]  r_dat0, r_dat1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    main_memory #(.WIDTH(W), .LINES(LINES), .LATENCY(LAT)) dut (
        .clk(clk),
        .reset(reset),
        .mem0_write_req(w_req[0]),
        .mem0_write_addr(w_addr[0]),
        .mem0_write_data(w_dat[0]),
        .mem0_write_ack(w_ack0),
        .mem0_read_req(r_req[0]),
        .mem0_read_addr(r_addr[0]),
        .mem0_read_data(r_dat0),
        .mem0_read_ack(r_ack0),
        .mem1_write_req(w_req[1]),
        .mem1_write_addr(w_addr[1]),
        .mem1_write_data(w_dat[1]),
        .mem1_write_ack(w_ack1),
        .mem1_read_req(r_req[1]),
        .mem1_read_addr(r_addr[1]),
        .mem1_read_data(r_dat1),
        .mem1_read_ack(r_ack1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time on a cycle timeline (sample at t0, commit/ack at t0+LAT, free again at t0+LAT+2).
    int            cyc = 0;
    int            m_t0 = 0;
    bit            m_busy = 1'b0, m_last = 1'b1, m_port = 1'b0, m_wr = 1'b0;
    bit            p0, p1, g;
    int unsigned   m_idx = 0;
    logic [W-1:0]  m_dat = '0;
    logic [W-1:0]  m_mem [LINES] = '{default: '0};
    logic [W-1:0]  m_rd  [2] = '{default: '0};
    logic [3:0]    exp_ack = '0;

    always @(posedge clk) begin
        cyc++;
        exp_ack = '0;
        if (!reset) begin
            m_busy  = 1'b0;
            m_last  = 1'b1;
            m_rd[0] = '0;
            m_rd[1] = '0;
        end else if (m_busy && cyc == m_t0 + LAT) begin
            if (m_wr) m_mem[m_idx] = m_dat;
            else      m_rd[m_port] = m_mem[m_idx];
            exp_ack[m_port ? (m_wr ? 2 : 3) : (m_wr ? 0 : 1)] = 1'b1;
        end else if (m_busy && cyc == m_t0 + LAT + 1) begin
            m_last = m_port;
            m_busy = 1'b0;
        end else if (!m_busy) begin
            p0 = w_req[0] | r_req[0];
            p1 = w_req[1] | r_req[1];
            if (p0 || p1) begin
                g      = (p0 && p1) ? !m_last : p1;
                m_port = g;
                m_wr   = w_req[g];
                m_idx  = ((m_wr ? w_addr[g] : r_addr[g]) / BYTES) % LINES;
                m_dat  = w_dat[g];
                m_t0   = cyc;
                m_busy = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("ack_vector", 64'({r_ack1, w_ack1, r_ack0, w_ack0}), 64'(exp_ack));
        check("read_data0", 64'(r_dat0), 64'(m_rd[0]));
        check("read_data1", 64'(r_dat1), 64'(m_rd[1]));
    end

    function automatic logic get_ack(input int p, input bit wr);
        if (p == 0) return wr ? w_ack0 : r_ack0;
        return wr ? w_ack1 : r_ack1;
    endfunction

    task automatic start(input int p, input bit wr, input bit rd, input int unsigned waddr,
                         input logic [W-1:0] wdat, input int unsigned raddr);
        w_addr[p] = AW'(waddr);
        w_dat[p]  = wdat;
        r_addr[p] = AW'(raddr);
        w_req[p]  = wr;
        r_req[p]  = rd;
    endtask

    // lat = k when the ack is visible right after the k-th edge counted from the sampling edge 0.
    task automatic wait_ack(input int p, input bit wr, input int drop_at, output int lat);
        lat = -1;
        for (int k = 0; k < BUDGET; k++) begin
            @(negedge clk);
            if (k == drop_at && wr) w_req[p] = 1'b0;
            if (get_ack(p, wr)) begin
                lat = k;
                break;
            end
        end
        if (wr) w_req[p] = 1'b0;
        else    r_req[p] = 1'b0;
    endtask

    task automatic rand_port(input int p, input int n);
        bit pw, pr;
        int kind;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            kind      = int'($urandom_range(0, 2));
            w_addr[p] = $urandom;
            r_addr[p] = $urandom;
            w_dat[p]  = $urandom;
            pw        = (kind != 1);
            pr        = (kind != 0);
            w_req[p]  = pw;
            r_req[p]  = pr;
            for (int k = 0; k < BUDGET && (pw || pr); k++) begin
                @(negedge clk);
                if (pw && get_ack(p, 1'b1)) begin pw = 1'b0; w_req[p] = 1'b0; end
                if (pr && get_ack(p, 1'b0)) begin pr = 1'b0; r_req[p] = 1'b0; end
                if (pw && w_req[p] && m_busy && m_port == p[0] && m_wr && $urandom_range(0, 7) == 0)
                    w_req[p] = 1'b0;
            end
            check("rand_all_acked", 64'({pw, pr}), 64'd0);
            w_req[p] = 1'b0;
            r_req[p] = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running after 50000 cycles");
        $fatal(1);
    end

    initial begin
        int lat, lat_a, lat_b, n_ack;
        repeat (3) @(negedge clk);
        check("reset_acks", 64'({r_ack1, w_ack1, r_ack0, w_ack0}), 64'd0);
        check("reset_rdata0", 64'(r_dat0), 64'd0);
        check("reset_rdata1", 64'(r_dat1), 64'd0);
        reset = 1'b1;

        // Single write then read on port 0, latency 10
        @(negedge clk); start(0, 1, 0, 5 * BYTES, 32'hA5A5A5A5, 0);
        wait_ack(0, 1, -1, lat);  check("p0_write_latency", 64'(lat), 64'd10);
        @(negedge clk); start(0, 0, 1, 0, '0, 5 * BYTES);
        wait_ack(0, 0, -1, lat);  check("p0_read_latency", 64'(lat), 64'd10);
        check("p0_read_data", 64'(r_dat0), 64'hA5A5A5A5);

        // Port 1 write line 3, read back through a wrapped address
        @(negedge clk); start(1, 1, 0, 3 * BYTES, 32'hDEADBEEF, 0);
        wait_ack(1, 1, -1, lat);  check("p1_write_latency", 64'(lat), 64'd10);
        @(negedge clk); start(1, 0, 1, 0, '0, (LINES + 3) * BYTES);
        wait_ack(1, 0, -1, lat);  check("wrap_read_latency", 64'(lat), 64'd10);
        check("wrap_read_data", 64'(r_dat1), 64'hDEADBEEF);

        // Round-robin after reset: port 0 first, twice
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk); reset = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            @(negedge clk);
            start(0, 0, 1, 0, '0, 5 * BYTES);
            start(1, 0, 1, 0, '0, 3 * BYTES);
            fork
                wait_ack(0, 0, -1, lat_a);
                wait_ack(1, 0, -1, lat_b);
            join
            check("rr_port0_latency", 64'(lat_a), 64'd10);
            check("rr_port1_latency", 64'(lat_b), 64'd22);
            check("rr_port0_data", 64'(r_dat0), 64'hA5A5A5A5);
            check("rr_port1_data", 64'(r_dat1), 64'hDEADBEEF);
        end

        // Evict plus fill from port 1: write first, read of another line after
        @(negedge clk); start(1, 1, 1, 8 * BYTES, 32'h12345678, 5 * BYTES);
        fork
            wait_ack(1, 1, -1, lat_a);
            wait_ack(1, 0, -1, lat_b);
        join
        check("evict_write_latency", 64'(lat_a), 64'd10);
        check("evict_read_latency", 64'(lat_b), 64'd22);
        check("evict_read_data", 64'(r_dat1), 64'hA5A5A5A5);

        // Reset in the middle of a write: no ack, line untouched, read data cleared
        @(negedge clk); start(0, 1, 0, 7 * BYTES, 32'h11, 0);
        wait_ack(0, 1, -1, lat);  check("line7_init_latency", 64'(lat), 64'd10);
        @(negedge clk); start(0, 1, 0, 7 * BYTES, 32'h77, 0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        w_req[0] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("midreset_rdata0", 64'(r_dat0), 64'd0);
        check("midreset_rdata1", 64'(r_dat1), 64'd0);
        n_ack = 0;
        repeat (15) begin
            @(negedge clk);
            n_ack += int'(w_ack0) + int'(r_ack0) + int'(w_ack1) + int'(r_ack1);
        end
        check("midreset_no_ack", 64'(n_ack), 64'd0);
        @(negedge clk); start(1, 0, 1, 0, '0, 7 * BYTES);
        wait_ack(1, 0, -1, lat);  check("midreset_read_latency", 64'(lat), 64'd10);
        check("midreset_line7", 64'(r_dat1), 64'h11);

        // Write request dropped during BUSY still commits and acks
        @(negedge clk); start(0, 1, 0, 2 * BYTES, 32'hCAFEF00D, 0);
        wait_ack(0, 1, 3, lat);   check("dropped_write_latency", 64'(lat), 64'd10);
        @(negedge clk); start(0, 0, 1, 0, '0, 2 * BYTES);
        wait_ack(0, 0, -1, lat);  check("dropped_write_readback", 64'(r_dat0), 64'hCAFEF00D);

        // Random concurrent traffic on both ports
        @(negedge clk);
        fork
            rand_port(0, 30);
            rand_port(1, 30);
        join
        repeat (LAT + 4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
